// File: rtl/spi_ram_pkg.sv
// Shared constants and FSM encoding for the SPI-to-RAM bridge.
package spi_ram_pkg;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam int         RD_LAT    = 2;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD,
        WR,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_ram_ctrl_sync.sv
// Two-flop synchroniser with edge detection on the synchronised level.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic meta_q, sync_q, prev_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= i_d;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign o_q    = sync_q;
    assign o_rise = sync_q & ~prev_q;
    assign o_fall = ~sync_q & prev_q;

endmodule

// File: rtl/spi_ram_ctrl.sv
// SPI slave (mode 0) bridging READ/WRITE opcodes onto a byte-wide RAM port
// with auto-incrementing address for burst transfers.
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int depth = 65536,
    parameter int aw    = $clog2(depth)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_spi_sclk,
    input  logic          i_spi_cs_n,
    input  logic          i_spi_mosi,
    output logic          o_spi_miso,
    output logic [aw-1:0] o_addr,
    output logic [7:0]    o_wdata,
    output logic          o_we,
    output logic          o_re,
    input  logic [7:0]    i_rdata,
    output logic          o_busy
);

    logic sclk_rise, sclk_fall, sclk_s_unused;
    logic cs_rise, cs_fall, cs_n_s;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_spi_sclk),
        .o_q(sclk_s_unused), .o_rise(sclk_rise), .o_fall(sclk_fall));
    spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_spi_cs_n),
        .o_q(cs_n_s), .o_rise(cs_rise), .o_fall(cs_fall));
    spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_d(i_spi_mosi),
        .o_q(mosi_s), .o_rise(mosi_rise_unused), .o_fall(mosi_fall_unused));

    state_t            state_q, state_d;
    logic [3:0]        bit_cnt_q;
    logic [14:0]       shift_q;
    logic              is_rd_q;
    logic [aw-1:0]     addr_q;
    logic [7:0]        wdata_q;
    logic [1:0]        we_cnt_q;
    logic [RD_LAT:0]   rd_pipe_q;
    logic [7:0]        tx_q;

    logic [7:0]        byte_in;
    logic [15:0]       addr_in;
    logic [aw-1:0]     addr_nxt;
    logic              last_bit, cnt_en, shift_en;
    logic              cmd_done, addr_done, rd_byte, wr_byte, fetch;

    assign byte_in  = {shift_q[6:0], mosi_s};
    assign addr_in  = {shift_q, mosi_s};
    assign addr_nxt = (addr_q == aw'(depth - 1)) ? '0 : addr_q + aw'(1);
    assign last_bit = (state_q == ADDR) ? (bit_cnt_q == 4'd15) : (bit_cnt_q == 4'd7);
    assign fetch    = (addr_done && is_rd_q) || rd_byte;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (cs_fall) state_d = CMD;
                CMD:  if (cmd_done)
                          state_d = (byte_in == CMD_READ || byte_in == CMD_WRITE) ? ADDR : IGNORE;
                ADDR: if (addr_done) state_d = is_rd_q ? RD : WR;
                default: ;
            endcase
        end
    end

    always_comb begin
        cnt_en     = 1'b0;
        shift_en   = 1'b0;
        cmd_done   = 1'b0;
        addr_done  = 1'b0;
        rd_byte    = 1'b0;
        wr_byte    = 1'b0;
        o_spi_miso = 1'b0;
        case (state_q)
            CMD:  begin cnt_en = sclk_rise; shift_en = sclk_rise; cmd_done  = sclk_rise && last_bit; end
            ADDR: begin cnt_en = sclk_rise; shift_en = sclk_rise; addr_done = sclk_rise && last_bit; end
            WR:   begin cnt_en = sclk_rise; shift_en = sclk_rise; wr_byte   = sclk_rise && last_bit; end
            RD:   begin cnt_en = sclk_rise; rd_byte = sclk_rise && last_bit; o_spi_miso = tx_q[7]; end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            is_rd_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_cnt_q  <= '0;
            rd_pipe_q <= '0;
            tx_q      <= '0;
        end else begin
            if (cs_rise || (state_q == IDLE && cs_fall)) bit_cnt_q <= '0;
            else if (cnt_en) bit_cnt_q <= last_bit ? 4'd0 : bit_cnt_q + 4'd1;

            if (shift_en) shift_q <= {shift_q[13:0], mosi_s};
            if (cmd_done) is_rd_q <= (byte_in == CMD_READ);

            rd_pipe_q <= {rd_pipe_q[RD_LAT-1:0], fetch};
            // The fall right after a byte boundary must keep the freshly loaded MSB on MISO.
            if (rd_pipe_q[RD_LAT]) tx_q <= i_rdata;
            else if (state_q == RD && sclk_fall && bit_cnt_q != 4'd0) tx_q <= {tx_q[6:0], 1'b0};

            // The strobe runs independently of the FSM so a CS_n rise cannot truncate it.
            if (wr_byte) begin
                wdata_q  <= byte_in;
                we_cnt_q <= 2'd2;
            end else if (we_cnt_q != 2'd0) begin
                we_cnt_q <= we_cnt_q - 2'd1;
            end

            if (addr_done) addr_q <= addr_in[aw-1:0];
            else if (rd_byte || we_cnt_q == 2'd1) addr_q <= addr_nxt;
        end
    end

    assign o_addr  = addr_q;
    assign o_wdata = wdata_q;
    assign o_we    = (we_cnt_q == 2'd0);
    assign o_re    = rd_pipe_q[0];
    assign o_busy  = ~cs_n_s;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench: an SPI master drives directed transactions, monitors check
// RAM write strobes and MISO bytes against queued expectations.
module tb_spi_ram_ctrl;

    localparam int HALF = 100;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic        o_spi_miso, o_we, o_re, o_busy;
    logic [15:0] o_addr;
    logic [7:0]  o_wdata, i_rdata;

    int vectors = 0, miscompares = 0;
    int we_pulses = 0, re_cyc = 0, miso_hi = 0;
    int r0, w0, m0;
    logic rd_phase = 1'b0;

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;
    wr_t        wr_exp[$];
    logic [7:0] rd_exp[$];

    always #5 clk = ~clk;

    spi_ram_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_spi_sclk(sclk), .i_spi_cs_n(cs_n), .i_spi_mosi(mosi), .o_spi_miso(o_spi_miso),
        .o_addr(o_addr), .o_wdata(o_wdata), .o_we(o_we), .o_re(o_re),
        .i_rdata(i_rdata), .o_busy(o_busy));

    // RAM model with two-cycle read latency
    logic [7:0] mem [0:65535];
    logic [7:0] rd1, rd2;
    always @(posedge clk) begin
        if (!rst_n) mem[16'h0011] <= 8'h5C;
        else if (!o_we) mem[o_addr] <= o_wdata;
        rd1 <= mem[o_addr];
        rd2 <= rd1;
    end
    assign i_rdata = rd2;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Write-strobe monitor
    logic we_prev = 1'b1;
    int   we_w = 0;
    wr_t  cur, e;
    always @(negedge clk) begin
        if (!o_we && o_re) begin
            miscompares++;
            $display("FAIL re_we_overlap: o_re=1 and o_we=0 together at %0t", $time);
        end
        if (o_re) re_cyc++;
        if (o_spi_miso) miso_hi++;
        if (!o_we) begin
            if (we_prev) begin
                we_pulses++;
                we_w = 1;
                cur.addr = o_addr;
                cur.data = o_wdata;
                if (wr_exp.size() == 0) begin
                    miscompares++;
                    $display("FAIL wr_unexpected: addr %0h data %0h with none expected", o_addr, o_wdata);
                end else begin
                    e = wr_exp.pop_front();
                    check("wr_addr", o_addr, e.addr);
                    check("wr_data", o_wdata, e.data);
                end
            end else begin
                we_w++;
                check("wr_stable", {o_addr, o_wdata}, {cur.addr, cur.data});
            end
        end else if (!we_prev) begin
            check("wr_width", we_w, 2);
        end
        we_prev = o_we;
    end

    // MISO monitor: master samples on SCLK rise
    logic [7:0] rx_sh = 8'h00;
    int         rx_n = 0;
    always @(posedge sclk) begin
        if (rd_phase) begin
            rx_sh = {rx_sh[6:0], o_spi_miso};
            rx_n++;
            if (rx_n == 8) begin
                rx_n = 0;
                if (rd_exp.size() == 0) begin
                    miscompares++;
                    $display("FAIL rd_unexpected: got %02h with none expected", rx_sh);
                end else begin
                    check("miso_byte", rx_sh, rd_exp.pop_front());
                end
            end
        end
    end

    task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        wr_exp.push_back(w);
    endtask

    task automatic cs_lo();
        cs_n = 1'b0;
        #(HALF);
    endtask

    task automatic cs_hi();
        #(HALF);
        cs_n = 1'b1;
        #(4*HALF);
    endtask

    task automatic spi_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            #(HALF);
            sclk = 1'b1;
            #(HALF);
            sclk = 1'b0;
        end
        mosi = 1'b0;
    endtask

    task automatic hdr(input logic [7:0] op, input logic [15:0] a);
        cs_lo();
        spi_bits(op, 8);
        spi_bits(a[15:8], 8);
        spi_bits(a[7:0], 8);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_addr", o_addr, 16'h0000);
        check("rst_wdata", o_wdata, 8'h00);
        check("rst_we", o_we, 1'b1);
        check("rst_re", o_re, 1'b0);
        check("rst_miso", o_spi_miso, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // single write A5 -> 0x0010
        push_wr(16'h0010, 8'hA5);
        hdr(8'h02, 16'h0010);
        check("busy_active", o_busy, 1'b1);
        spi_bits(8'hA5, 8);
        cs_hi();
        check("busy_idle", o_busy, 1'b0);

        // read back 0x0010, continue into preloaded 0x0011
        rd_exp.push_back(8'hA5);
        rd_exp.push_back(8'h5C);
        r0 = re_cyc;
        hdr(8'h03, 16'h0010);
        rd_phase = 1'b1;
        spi_bits(8'h00, 8);
        spi_bits(8'h00, 8);
        rd_phase = 1'b0;
        cs_hi();
        check("rd_fetches", re_cyc - r0, 3);
        check("miso_idle", o_spi_miso, 1'b0);

        // burst write across the top of memory
        push_wr(16'hFFFF, 8'h11);
        push_wr(16'h0000, 8'h22);
        hdr(8'h02, 16'hFFFF);
        spi_bits(8'h11, 8);
        spi_bits(8'h22, 8);
        cs_hi();

        rd_exp.push_back(8'h11);
        rd_exp.push_back(8'h22);
        hdr(8'h03, 16'hFFFF);
        rd_phase = 1'b1;
        spi_bits(8'h00, 8);
        spi_bits(8'h00, 8);
        rd_phase = 1'b0;
        cs_hi();

        // unknown opcode: no RAM traffic, MISO quiet
        r0 = re_cyc; w0 = we_pulses; m0 = miso_hi;
        cs_lo();
        spi_bits(8'h9F, 8);
        for (int i = 0; i < 3; i++) spi_bits(8'hFF, 8);
        cs_hi();
        check("ign_re", re_cyc - r0, 0);
        check("ign_we", we_pulses - w0, 0);
        check("ign_miso", miso_hi - m0, 0);

        // partial write byte is dropped
        w0 = we_pulses;
        hdr(8'h02, 16'h0020);
        spi_bits(8'hFF, 5);
        cs_hi();
        check("partial_we", we_pulses - w0, 0);
        check("partial_addr", o_addr, 16'h0020);
        check("partial_busy", o_busy, 1'b0);

        push_wr(16'h0021, 8'h3C);
        hdr(8'h02, 16'h0021);
        spi_bits(8'h3C, 8);
        cs_hi();

        // reset in the middle of a read address phase
        cs_lo();
        spi_bits(8'h03, 8);
        spi_bits(8'h00, 8);
        rst_n = 1'b0;
        #1;
        check("mid_rst_addr", o_addr, 16'h0000);
        check("mid_rst_wdata", o_wdata, 8'h00);
        check("mid_rst_we", o_we, 1'b1);
        check("mid_rst_re", o_re, 1'b0);
        check("mid_rst_miso", o_spi_miso, 1'b0);
        check("mid_rst_busy", o_busy, 1'b0);
        @(negedge clk);
        cs_n = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        rd_exp.push_back(8'h3C);
        hdr(8'h03, 16'h0021);
        rd_phase = 1'b1;
        spi_bits(8'h00, 8);
        rd_phase = 1'b0;
        cs_hi();

        repeat (20) @(negedge clk);
        check("wr_exp_drained", wr_exp.size(), 0);
        check("rd_exp_drained", rd_exp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
